frame_scanout: RTL and testbench

Raster-order reader for the solver result memories. After a solve completes, it walks every pixel of the frame and issues reads on the solver-bank read port (`rd_solver_id`, `rd_addr`, `rd_data_in`). It then maps each 4-bit signed result to an RGB332 colour and streams the pixels to the display FIFO over a valid/ready handshake. It is the read-side counterpart of the multi-solver bank: pixel index p is held in bank `p mod NUM_SOLVERS` at word `p div NUM_SOLVERS`.

---
 rtl/fractal_pkg.sv | 37 +++
 rtl/frame_scanout_if.sv | 30 +++
 rtl/pixel_fifo2.sv | 51 +++++
 rtl/frame_scanout.sv | 156 +++++++++++++++
 tb/tb_frame_scanout.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fractal_pkg.sv
// Shared types and constants for the fractal solver read side: result widths,
// RGB332 palette, scan FSM states and the buffered pixel record.
package fractal_pkg;

  localparam int unsigned RESULT_W    = 4;
  localparam int unsigned ADDR_W      = 19;
  localparam int unsigned SOLVER_ID_W = 6;
  localparam int unsigned X_W         = 10;
  localparam int unsigned Y_W         = 9;

  localparam logic [7:0] PALETTE [0:7] = '{
    8'h92, 8'hE0, 8'hFC, 8'h1C, 8'h1F, 8'h03, 8'hE3, 8'hFF
  };

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain
  } state_e;

  typedef struct packed {
    logic [7:0]     color;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           sof;
    logic           eol;
  } pix_entry_t;

  // Negative results are inside the set and render black.
  function automatic logic [7:0] color_map(input logic [RESULT_W-1:0] v);
    if (v[RESULT_W-1]) begin
      return 8'h00;
    end
    return PALETTE[v[2:0]];
  endfunction

endpackage

// File: rtl/frame_scanout_if.sv
// Solver-bank read port plus the pixel stream towards the display FIFO.
interface frame_scanout_if;
  import fractal_pkg::*;

  logic [SOLVER_ID_W-1:0] rd_solver_id;
  logic [ADDR_W-1:0]      rd_addr;
  logic [RESULT_W-1:0]    rd_data_in;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [7:0]             pix_data;
  logic [X_W-1:0]         pix_x;
  logic [Y_W-1:0]         pix_y;
  logic                   pix_sof;
  logic                   pix_eol;

  modport master (
    output rd_solver_id, rd_addr,
    input  rd_data_in,
    output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
    input  pix_ready
  );

  modport slave (
    input  rd_solver_id, rd_addr,
    output rd_data_in,
    input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
    output pix_ready
  );

endinterface

// File: rtl/pixel_fifo2.sv
// Two-entry FIFO with occupancy output, same-cycle push/pop and synchronous flush.
module pixel_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/frame_scanout.sv
// Raster-order scan of the interleaved solver banks: one read per cycle under a
// credit limit, colour-mapped into a 2-entry buffer and streamed out valid/ready.
module frame_scanout import fractal_pkg::*; #(
  parameter int unsigned NUM_SOLVERS = 1,
  parameter int unsigned NUM_COLUMNS = 640,
  parameter int unsigned NUM_ROWS    = 480
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   solver_done_i,
  frame_scanout_if.master        bus,
  output logic                   busy_o,
  output logic                   aborted_o,
  output logic [15:0]            frame_count_o
);

  localparam logic [SOLVER_ID_W-1:0] BankLast = SOLVER_ID_W'(NUM_SOLVERS - 1);
  localparam logic [X_W-1:0]         ColLast  = X_W'(NUM_COLUMNS - 1);
  localparam logic [Y_W-1:0]         RowLast  = Y_W'(NUM_ROWS - 1);

  state_e                 state_q;
  logic [SOLVER_ID_W-1:0] bank_q;
  logic [ADDR_W-1:0]      word_q;
  logic [X_W-1:0]         x_q;
  logic [Y_W-1:0]         y_q;
  logic                   rd_pend_q;
  logic [X_W-1:0]         pend_x_q;
  logic [Y_W-1:0]         pend_y_q;
  logic                   pend_sof_q;
  logic                   pend_eol_q;
  logic                   aborted_q;
  logic [15:0]            frame_count_q;

  logic       active;
  logic       abort;
  logic       pop;
  logic       issue;
  logic       last_px;
  logic [2:0] occupancy;
  logic [1:0] fifo_count;
  pix_entry_t push_entry;
  pix_entry_t head;

  assign active  = (state_q != StIdle);
  assign abort   = active && !solver_done_i;
  assign pop     = bus.pix_valid && bus.pix_ready;
  assign last_px = (x_q == ColLast) && (y_q == RowLast);

  // Slots committed after this cycle's pop; a new read needs one to spare.
  assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue     = (state_q == StStream) && solver_done_i && (occupancy <= 3'd1);

  always_comb begin
    push_entry       = '0;
    push_entry.color = color_map(bus.rd_data_in);
    push_entry.x     = pend_x_q;
    push_entry.y     = pend_y_q;
    push_entry.sof   = pend_sof_q;
    push_entry.eol   = pend_eol_q;
  end

  pixel_fifo2 #(
    .Width($bits(pix_entry_t))
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (abort),
    .push_i  (rd_pend_q),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      bank_q        <= '0;
      word_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      rd_pend_q     <= 1'b0;
      pend_x_q      <= '0;
      pend_y_q      <= '0;
      pend_sof_q    <= 1'b0;
      pend_eol_q    <= 1'b0;
      aborted_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      aborted_q <= 1'b0;
      case (state_q)
        StIdle: begin
          rd_pend_q <= 1'b0;
          if (start_i && solver_done_i) begin
            state_q <= StStream;
            bank_q  <= '0;
            word_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        StStream, StDrain: begin
          if (abort) begin
            state_q   <= StIdle;
            rd_pend_q <= 1'b0;
            aborted_q <= 1'b1;
          end else begin
            rd_pend_q <= issue;
            if (issue) begin
              pend_x_q   <= x_q;
              pend_y_q   <= y_q;
              pend_sof_q <= (x_q == '0) && (y_q == '0);
              pend_eol_q <= (x_q == ColLast);
              if (last_px) begin
                // Address is left on the final pixel rather than stepping past it.
                state_q <= StDrain;
              end else begin
                if (bank_q == BankLast) begin
                  bank_q <= '0;
                  word_q <= word_q + 1'b1;
                end else begin
                  bank_q <= bank_q + 1'b1;
                end
                if (x_q == ColLast) begin
                  x_q <= '0;
                  y_q <= y_q + 1'b1;
                end else begin
                  x_q <= x_q + 1'b1;
                end
              end
            end
            if ((state_q == StDrain) && (fifo_count == 2'd0) && !rd_pend_q) begin
              state_q       <= StIdle;
              frame_count_q <= frame_count_q + 16'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rd_solver_id = bank_q;
  assign bus.rd_addr      = word_q;
  assign bus.pix_valid    = (fifo_count != 2'd0);
  assign bus.pix_data     = head.color;
  assign bus.pix_x        = head.x;
  assign bus.pix_y        = head.y;
  assign bus.pix_sof      = head.sof;
  assign bus.pix_eol      = head.eol;
  assign busy_o           = active;
  assign aborted_o        = aborted_q;
  assign frame_count_o    = frame_count_q;

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout on a 3-bank 8x4 frame: bank memory model, handshake
// monitor and a raster/palette reference computed from pixel indices.
module tb_frame_scanout;
  import fractal_pkg::*;

  localparam int NS   = 3;
  localparam int NC   = 8;
  localparam int NR   = 4;
  localparam int NPIX = NC * NR;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] x;
    logic [8:0] y;
    logic       sof;
    logic       eol;
  } px_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        solver_done = 1'b0;
  logic        busy;
  logic        aborted;
  logic [15:0] frame_count;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  exp_fc   = 0;
  px_t obs_q[$];

  frame_scanout_if bus ();

  frame_scanout #(
    .NUM_SOLVERS (NS),
    .NUM_COLUMNS (NC),
    .NUM_ROWS    (NR)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_i       (start),
    .solver_done_i (solver_done),
    .bus           (bus.master),
    .busy_o        (busy),
    .aborted_o     (aborted),
    .frame_count_o (frame_count)
  );

  always #5 clock = ~clock;

  // Bank b word w holds pixel p = w*NS + b, value (p mod 9) - 1, one cycle after the address.
  always @(posedge clock) begin
    bus.rd_data_in <= 4'(((int'(bus.rd_addr) * NS + int'(bus.rd_solver_id)) % 9) - 1);
  end

  function automatic px_t exp_px(input int p);
    px_t e;
    int  v;
    v      = (p % 9) - 1;
    e.data = (v < 0) ? 8'h00 : PALETTE[v[2:0]];
    e.x    = 10'(p % NC);
    e.y    = 9'(p / NC);
    e.sof  = (p == 0);
    e.eol  = ((p % NC) == NC - 1);
    return e;
  endfunction

  px_t  cur_px;
  px_t  prev_px     = '0;
  logic prev_valid  = 1'b0;
  logic prev_ready  = 1'b0;
  logic prev_rst    = 1'b1;
  logic prev_sd     = 1'b0;

  always @(negedge clock) begin
    cur_px = {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_sof, bus.pix_eol};
    if (prev_valid && !prev_ready && !prev_rst && prev_sd) begin
      n_assert++;
      if (bus.pix_valid !== 1'b1 || cur_px !== prev_px) begin
        n_fail++;
        $display("FAIL stall_stable: got valid=%b fields=%h, required valid=1 fields=%h",
                 bus.pix_valid, cur_px, prev_px);
      end
    end
    if (busy === 1'b1 && !reset) begin
      n_assert++;
      if (int'(bus.rd_addr) * NS + int'(bus.rd_solver_id) - obs_q.size() > 2) begin
        n_fail++;
        $display("FAIL credit: next read index %0d with %0d accepted, required at most 2 ahead",
                 int'(bus.rd_addr) * NS + int'(bus.rd_solver_id), obs_q.size());
      end
    end
    if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) obs_q.push_back(cur_px);
    prev_px    = cur_px;
    prev_valid = bus.pix_valid;
    prev_ready = bus.pix_ready;
    prev_rst   = reset;
    prev_sd    = solver_done;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_until_idle(input int budget, output bit ok);
    for (int i = 0; i < budget && busy; i++) tick();
    ok = !busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    solver_done = 1'b0;
    repeat (3) tick();
    n_assert++;
    if ({busy, aborted, bus.pix_valid, bus.pix_sof, bus.pix_eol} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {busy, aborted, bus.pix_valid, bus.pix_sof, bus.pix_eol});
    end
    n_assert++;
    if ({bus.pix_data, bus.pix_x, bus.pix_y} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_fields: got %h required 0", {bus.pix_data, bus.pix_x, bus.pix_y});
    end
    n_assert++;
    if ({bus.rd_solver_id, bus.rd_addr, frame_count} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_addr_fc: got %h required 0", {bus.rd_solver_id, bus.rd_addr, frame_count});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_frame();
    bit ok;
    obs_q.delete();
    solver_done   = 1'b1;
    bus.pix_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_idle(200, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL full_timeout: busy still %b, required 0", busy); end
    n_assert++;
    if (obs_q.size() != NPIX) begin
      n_fail++;
      $display("FAIL full_count: got %0d pixels required %0d", obs_q.size(), NPIX);
    end
    for (int p = 0; p < obs_q.size() && p < NPIX; p++) begin
      n_assert++;
      if (obs_q[p] !== exp_px(p)) begin
        n_fail++;
        $display("FAIL full_px[%0d]: got %h required %h", p, obs_q[p], exp_px(p));
      end
    end
    exp_fc++;
    n_assert++;
    if (frame_count !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL full_fc: got %0d required %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_latency();
    int cycles;
    obs_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_assert++;
    if ({busy, bus.pix_valid, bus.rd_solver_id, bus.rd_addr} !== {1'b1, 1'b0, 6'd0, 19'd0}) begin
      n_fail++;
      $display("FAIL lat_cycle1: got busy=%b valid=%b bank=%0d word=%0d, required 1 0 0 0",
               busy, bus.pix_valid, bus.rd_solver_id, bus.rd_addr);
    end
    tick();
    n_assert++;
    if (bus.pix_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_cycle2: got valid=%b required 0", bus.pix_valid);
    end
    tick();
    n_assert++;
    if (bus.pix_valid !== 1'b1 || bus.pix_data !== 8'h00 || bus.pix_sof !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_cycle3: got valid=%b data=%h sof=%b, required 1 00 1",
               bus.pix_valid, bus.pix_data, bus.pix_sof);
    end
    cycles = 0;
    while (busy && cycles < 200) begin
      n_assert++;
      if (frame_count !== 16'(exp_fc)) begin
        n_fail++; $display("FAIL lat_fc_early: got %0d required %0d", frame_count, exp_fc);
      end
      tick();
      cycles++;
    end
    exp_fc++;
    n_assert++;
    if (busy !== 1'b0 || frame_count !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL lat_end: got busy=%b fc=%0d required 0 %0d", busy, frame_count, exp_fc);
    end
    n_assert++;
    if (obs_q.size() != NPIX || obs_q[obs_q.size() - 1] !== exp_px(NPIX - 1)) begin
      n_fail++; $display("FAIL lat_last_px: got %0d pixels, required %0d ending in pixel 31",
                         obs_q.size(), NPIX);
    end
    n_assert++;
    if (bus.rd_solver_id !== 6'd1 || bus.rd_addr !== 19'd10) begin
      n_fail++;
      $display("FAIL lat_last_addr: got bank=%0d word=%0d required bank=1 word=10",
               bus.rd_solver_id, bus.rd_addr);
    end
  endtask

  task automatic test_random_ready();
    bit ok;
    for (int f = 0; f < 3; f++) begin
      obs_q.delete();
      bus.pix_ready = 1'($urandom_range(0, 1));
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2000 && busy; i++) begin
        bus.pix_ready = 1'($urandom_range(0, 1));
        tick();
      end
      ok = !busy;
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL rand_timeout[%0d]: busy %b required 0", f, busy); end
      n_assert++;
      if (obs_q.size() != NPIX) begin
        n_fail++;
        $display("FAIL rand_count[%0d]: got %0d required %0d", f, obs_q.size(), NPIX);
      end
      for (int p = 0; p < obs_q.size() && p < NPIX; p++) begin
        n_assert++;
        if (obs_q[p] !== exp_px(p)) begin
          n_fail++;
          $display("FAIL rand_px[%0d][%0d]: got %h required %h", f, p, obs_q[p], exp_px(p));
        end
      end
      exp_fc++;
      n_assert++;
      if (frame_count !== 16'(exp_fc)) begin
        n_fail++; $display("FAIL rand_fc[%0d]: got %0d required %0d", f, frame_count, exp_fc);
      end
    end
    bus.pix_ready = 1'b1;
  endtask

  task automatic test_abort();
    bit ok;
    bit found;
    obs_q.delete();
    bus.pix_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.pix_valid && bus.pix_x == 10'd5 && bus.pix_y == 9'd1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_assert++;
    if (!found) begin n_fail++; $display("FAIL abort_reach: pixel 13 got 0 required 1"); end
    solver_done = 1'b0;
    tick();
    n_assert++;
    if ({aborted, bus.pix_valid, busy} !== 3'b100 || frame_count !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL abort_pulse: got aborted=%b valid=%b busy=%b fc=%0d, required 1 0 0 %0d",
               aborted, bus.pix_valid, busy, frame_count, exp_fc);
    end
    tick();
    n_assert++;
    if (aborted !== 1'b0) begin
      n_fail++; $display("FAIL abort_width: got aborted=%b required 0", aborted);
    end
    solver_done = 1'b1;
    obs_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_idle(200, ok);
    n_assert++;
    if (!ok || obs_q.size() != NPIX) begin
      n_fail++;
      $display("FAIL abort_restart: got busy=%b pixels=%0d required 0 %0d", busy, obs_q.size(), NPIX);
    end
    for (int p = 0; p < obs_q.size() && p < NPIX; p++) begin
      n_assert++;
      if (obs_q[p] !== exp_px(p)) begin
        n_fail++;
        $display("FAIL abort_px[%0d]: got %h required %h", p, obs_q[p], exp_px(p));
      end
    end
    exp_fc++;
    n_assert++;
    if (frame_count !== 16'(exp_fc)) begin
      n_fail++; $display("FAIL abort_fc: got %0d required %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    solver_done = 1'b0;
    start = 1'b1;
    repeat (4) tick();
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL start_no_done: got busy=%b required 0", busy);
    end
    start = 1'b0;
    solver_done = 1'b1;
    tick();
    obs_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    run_until_idle(200, ok);
    n_assert++;
    if (!ok || obs_q.size() != NPIX) begin
      n_fail++;
      $display("FAIL start_ignored: got busy=%b pixels=%0d required 0 %0d", busy, obs_q.size(), NPIX);
    end
    for (int p = 0; p < obs_q.size() && p < NPIX; p++) begin
      n_assert++;
      if (obs_q[p] !== exp_px(p)) begin
        n_fail++;
        $display("FAIL start_px[%0d]: got %h required %h", p, obs_q[p], exp_px(p));
      end
    end
    exp_fc++;
    repeat (3) tick();
    n_assert++;
    if (busy !== 1'b0 || frame_count !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL start_after: got busy=%b fc=%0d required 0 %0d", busy, frame_count, exp_fc);
    end
  endtask

  task automatic test_reset_drain();
    bit found;
    obs_q.delete();
    bus.pix_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rd_solver_id == 6'd1 && bus.rd_addr == 19'd10) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    tick();
    bus.pix_ready = 1'b0;
    repeat (2) tick();
    n_assert++;
    if (!found || busy !== 1'b1 || bus.pix_valid !== 1'b1 || frame_count === 16'd0) begin
      n_fail++;
      $display("FAIL drain_setup: got found=%b busy=%b valid=%b fc=%0d, required 1 1 1 nonzero",
               found, busy, bus.pix_valid, frame_count);
    end
    reset = 1'b1;
    tick();
    n_assert++;
    if ({busy, aborted, bus.pix_valid, bus.pix_sof, bus.pix_eol} !== 5'b0) begin
      n_fail++;
      $display("FAIL drain_rst_ctrl: got %b required 00000",
               {busy, aborted, bus.pix_valid, bus.pix_sof, bus.pix_eol});
    end
    n_assert++;
    if ({bus.pix_data, bus.pix_x, bus.pix_y} !== 27'd0) begin
      n_fail++;
      $display("FAIL drain_rst_fields: got %h required 0", {bus.pix_data, bus.pix_x, bus.pix_y});
    end
    n_assert++;
    if ({bus.rd_solver_id, bus.rd_addr, frame_count} !== 41'd0) begin
      n_fail++;
      $display("FAIL drain_rst_addr_fc: got %h required 0",
               {bus.rd_solver_id, bus.rd_addr, frame_count});
    end
    reset = 1'b0;
    exp_fc = 0;
    bus.pix_ready = 1'b1;
    tick();
  endtask

  initial begin
    bus.pix_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_latency();
    test_random_ready();
    test_abort();
    test_start_ignored();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
